vector_issue_queue: RTL
=======================

VECTOR_ISSUE_QUEUE -- requirements
Module: vector_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-003 SHALL have dispatch ports: disp_valid_i in 1; disp_ready_o out 1; disp_vs1_i in 5; disp_vs2_i in 5; disp_vd_i in 5; disp_scalar_i in 32; disp_vec_op_i in 6; disp_rob_id_i in 6; disp_phys_dest_i in 7; disp_vtype_i in 11; disp_vl_i in 8.
REQ-004 SHALL have issue ports to the vector unit: issue_valid_o out 1; issue_ready_i in 1; issue_vs1_o, issue_vs2_o, issue_vd_o out 5; issue_scalar_o out 32; issue_vec_op_o out 6; issue_rob_id_o out 6; issue_phys_dest_o out 7; issue_vtype_o out 11; issue_vl_o out 8.
REQ-005 SHALL have writeback ports: wb_valid_i in 1, wb_vd_i in 5 (vector register write completed); flush_i in 1 (pipeline flush); count_o out log2(DEPTH)+1 (occupied entries); busy_o out 32 (pending-write bitmap).

Function
REQ-006 SHALL be an in-order FIFO; only the head entry may issue.
REQ-007 SHALL assert disp_ready_o iff count < DEPTH; no enqueue when full, even with a same-cycle dequeue.
REQ-008 SHALL enqueue on disp_valid_i && disp_ready_o, capturing all disp_* fields; the entry is visible at the head no earlier than the next cycle (no empty bypass).
REQ-009 SHALL drive issue_* fields combinationally from the head entry; values are don't-care when count is 0.
REQ-010 SHALL classify ops: writers = ALU (6'b000000-6'b010010), VDIV, VLOAD (6'b100000); VSTORE (6'b100001) reads vs2 and writes nothing; VSETVL (6'b111111) reads nothing and writes nothing.
REQ-011 SHALL assert issue_valid_o iff count>0, !flush_i, and the head is hazard-free: non-VSETVL ops require busy[vs1]=0, busy[vs2]=0, and busy[vd]=0 if a writer; VSETVL requires busy == 0.
REQ-012 SHALL use the registered busy bitmap for hazard checks (no same-cycle writeback bypass).
REQ-013 SHALL dequeue on issue_valid_o && issue_ready_i; a writer sets busy[vd] on that edge.
REQ-014 SHALL clear busy[wb_vd_i] on wb_valid_i; set and clear target different bits by construction; if both hit the same bit, set wins.
REQ-015 SHALL support simultaneous enqueue and dequeue with count unchanged; read and write pointers wrap modulo DEPTH.
REQ-016 SHALL, on flush_i, clear count, pointers and busy on the next edge and ignore dispatch and issue that cycle; disp_ready_o stays count-based.
REQ-017 SHALL hold a blocked head indefinitely with fields stable; issue_valid_o may deassert only via hazard or flush, never while issue_ready_i is low and the head is unchanged.

Reset
REQ-018 SHALL, on rst_n low, asynchronously set count=0, pointers=0, busy=0, issue_valid_o=0, disp_ready_o=1; entry payload storage is not reset.
REQ-019 SHALL, on reset mid-operation, discard all queued and pending state; the first dispatch after rst_n rises issues after 1 cycle if hazard-free.

Structure
REQ-020 SHALL take vector opcode localparams and field widths (5/6/7/11/8) from the shared clownfish_config package; opcode classification is a package function.
REQ-021 SHALL be a single module; the payload FIFO may be a sub-module named vec_iq_fifo.

Verification
REQ-022 Enqueue VADD_VV vs1=1 vs2=2 vd=3 into empty queue with issue_ready_i=1 -> issue_valid_o high the next cycle, fields match, busy=0x00000008 after issue.
REQ-023 Issue VADD vd=3, then VMUL vs1=3 -> VMUL held (issue_valid_o=0) until wb_valid_i with wb_vd_i=3, then issues the cycle after.
REQ-024 Dispatch 5 ops back-to-back with issue_ready_i=0 -> disp_ready_o low after 4th, count_o=4, 5th accepted only after the first dequeue.
REQ-025 With busy=0x00000010, enqueue VSETVL vtype=0x010 vl=4 -> held until busy==0, then issues with issue_vtype_o=0x010, issue_vl_o=4; VSTORE never sets busy.
REQ-026 With 3 entries and busy=0xF, assert flush_i -> next cycle count_o=0, busy_o=0, issue_valid_o=0; rst_n pulse mid-queue gives the same result asynchronously.

Source files
------------

// File: rtl/clownfish_config.sv
// Shared vector config: field widths, opcodes, issue-queue entry and op
// classification used by the vector issue queue and its payload FIFO.
package clownfish_config;

  localparam int XLEN    = 32;
  localparam int VREG_W  = 5;
  localparam int VOP_W   = 6;
  localparam int ROB_W   = 6;
  localparam int PDEST_W = 7;
  localparam int VTYPE_W = 11;
  localparam int VL_W    = 8;

  localparam logic [VOP_W-1:0] VOP_ALU_MAX = 6'h12;
  localparam logic [VOP_W-1:0] VOP_VDIV    = 6'h13;
  localparam logic [VOP_W-1:0] VOP_VLOAD   = 6'h20;
  localparam logic [VOP_W-1:0] VOP_VSETVL  = 6'h3F;

  typedef struct packed {
    logic [VREG_W-1:0]  vs1;
    logic [VREG_W-1:0]  vs2;
    logic [VREG_W-1:0]  vd;
    logic [XLEN-1:0]    scalar;
    logic [VOP_W-1:0]   vec_op;
    logic [ROB_W-1:0]   rob_id;
    logic [PDEST_W-1:0] phys_dest;
    logic [VTYPE_W-1:0] vtype;
    logic [VL_W-1:0]    vl;
  } viq_entry_t;

  function automatic logic vop_writes_vd(input logic [VOP_W-1:0] op);
    return (op <= VOP_ALU_MAX) || (op == VOP_VDIV) || (op == VOP_VLOAD);
  endfunction

endpackage

// File: rtl/vec_iq_fifo.sv
// Payload FIFO for the vector issue queue: push/pop/flush, head readout,
// occupancy count. Payload RAM is not reset.
module vec_iq_fifo
  import clownfish_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  viq_entry_t             data_i,
  output viq_entry_t             head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  viq_entry_t    mem_q [DEPTH];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/vector_issue_queue.sv
// In-order vector issue queue with a vector-register busy scoreboard.
// Ports: disp_* (enqueue), issue_* (head to vector unit), wb_* (clear busy),
// flush_i, count_o (occupancy), busy_o (pending-write bitmap).
module vector_issue_queue
  import clownfish_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic [VREG_W-1:0]      disp_vs1_i,
  input  logic [VREG_W-1:0]      disp_vs2_i,
  input  logic [VREG_W-1:0]      disp_vd_i,
  input  logic [XLEN-1:0]        disp_scalar_i,
  input  logic [VOP_W-1:0]       disp_vec_op_i,
  input  logic [ROB_W-1:0]       disp_rob_id_i,
  input  logic [PDEST_W-1:0]     disp_phys_dest_i,
  input  logic [VTYPE_W-1:0]     disp_vtype_i,
  input  logic [VL_W-1:0]        disp_vl_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [VREG_W-1:0]      issue_vs1_o,
  output logic [VREG_W-1:0]      issue_vs2_o,
  output logic [VREG_W-1:0]      issue_vd_o,
  output logic [XLEN-1:0]        issue_scalar_o,
  output logic [VOP_W-1:0]       issue_vec_op_o,
  output logic [ROB_W-1:0]       issue_rob_id_o,
  output logic [PDEST_W-1:0]     issue_phys_dest_o,
  output logic [VTYPE_W-1:0]     issue_vtype_o,
  output logic [VL_W-1:0]        issue_vl_o,
  input  logic                   wb_valid_i,
  input  logic [VREG_W-1:0]      wb_vd_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  viq_entry_t  din, head;
  logic        push, pop, hz_free, head_wr;
  logic [31:0] busy_q, busy_d;

  assign din = '{
    vs1: disp_vs1_i, vs2: disp_vs2_i, vd: disp_vd_i,
    scalar: disp_scalar_i, vec_op: disp_vec_op_i,
    rob_id: disp_rob_id_i, phys_dest: disp_phys_dest_i,
    vtype: disp_vtype_i, vl: disp_vl_i
  };

  assign disp_ready_o = count_o < CW'(DEPTH);
  assign push = disp_valid_i && disp_ready_o && !flush_i;
  assign head_wr = vop_writes_vd(head.vec_op);

  // vsetvl must drain every in-flight write before it changes vtype/vl
  always_comb begin
    if (head.vec_op == VOP_VSETVL) begin
      hz_free = (busy_q == '0);
    end else begin
      hz_free = !busy_q[head.vs1] && !busy_q[head.vs2] &&
                !(head_wr && busy_q[head.vd]);
    end
  end

  assign issue_valid_o = (count_o != '0) && !flush_i && hz_free;
  assign pop = issue_valid_o && issue_ready_i;

  // set after clear so an issuing writer wins over a same-bit writeback
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_vd_i] = 1'b0;
    if (pop && head_wr) busy_d[head.vd] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  vec_iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (din),
    .head_o  (head),
    .count_o (count_o)
  );

  assign issue_vs1_o       = head.vs1;
  assign issue_vs2_o       = head.vs2;
  assign issue_vd_o        = head.vd;
  assign issue_scalar_o    = head.scalar;
  assign issue_vec_op_o    = head.vec_op;
  assign issue_rob_id_o    = head.rob_id;
  assign issue_phys_dest_o = head.phys_dest;
  assign issue_vtype_o     = head.vtype;
  assign issue_vl_o        = head.vl;
  assign busy_o            = busy_q;

endmodule
